// File: rtl/exe_mem_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : exe_mem_stage_reg
// Purpose  : Elastic EXE/MEM pipeline register. Captures ALU result, store
//            data, destination register, write controls and branch target,
//            resolves the 8-way branch condition at accept time and counts
//            taken branches retired into MEM.
// Build    : define EXE_MEM_SKID_EN for a two-entry version with a skid
//            register and a registered exe_ready. Default build is a single
//            register with a combinational exe_ready.
// Ports    : clk/clr          clock, asynchronous active-high reset
//            exe_valid/ready  EXE-side handshake
//            exe_*            entry fields and ALU flags from EXE
//            flush            synchronous kill of all held entries
//            mem_valid/ready  MEM-side handshake
//            mem_*            entry fields to MEM (controls gated by valid)
//            branch_cnt       wrapping count of taken branches retired
// Revision : 1.0 - initial parametrised elastic release
// ============================================================================
module exe_mem_stage_reg #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              exe_valid,
  output logic              exe_ready,
  input  logic              exe_wreg,
  input  logic              exe_m2reg,
  input  logic              exe_wmem,
  input  logic [DATA_W-1:0] exe_alu,
  input  logic [DATA_W-1:0] exe_b,
  input  logic [RN_W-1:0]   exe_rn,
  input  logic              exe_z,
  input  logic              exe_neg,
  input  logic [2:0]        exe_bcond,
  input  logic [PC_W-1:0]   exe_bpc,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wreg,
  output logic              mem_m2reg,
  output logic              mem_wmem,
  output logic              mem_branch,
  output logic [DATA_W-1:0] mem_alu,
  output logic [DATA_W-1:0] mem_b,
  output logic [RN_W-1:0]   mem_rn,
  output logic [PC_W-1:0]   mem_bpc,
  output logic [CNT_W-1:0]  branch_cnt
);

  localparam int ENT_W = 4 + 2 * DATA_W + RN_W + PC_W;

  localparam logic [2:0] BC_NONE = 3'b000;
  localparam logic [2:0] BC_BEQ  = 3'b001;
  localparam logic [2:0] BC_BNE  = 3'b010;
  localparam logic [2:0] BC_BLEZ = 3'b011;
  localparam logic [2:0] BC_BGTZ = 3'b100;
  localparam logic [2:0] BC_BLTZ = 3'b101;
  localparam logic [2:0] BC_BGEZ = 3'b110;
  localparam logic [2:0] BC_ALW  = 3'b111;

  logic              w_taken;
  logic              w_accept;
  logic              w_xfer;
  logic [ENT_W-1:0]  w_in_ent;
  logic [ENT_W-1:0]  r_main;
  logic              r_main_valid;
  logic              w_wreg, w_m2reg, w_wmem, w_branch;
  logic [CNT_W-1:0]  r_cnt;

  // Branch outcome is resolved once, at accept, and travels with the entry.
  always_comb begin
    w_taken = 1'b0;
    case (exe_bcond)
      BC_NONE: w_taken = 1'b0;
      BC_BEQ:  w_taken = exe_z;
      BC_BNE:  w_taken = ~exe_z;
      BC_BLEZ: w_taken = exe_z | exe_neg;
      BC_BGTZ: w_taken = ~exe_z & ~exe_neg;
      BC_BLTZ: w_taken = exe_neg;
      BC_BGEZ: w_taken = ~exe_neg;
      BC_ALW:  w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_in_ent = {exe_wreg, exe_m2reg, exe_wmem, w_taken,
                     exe_alu, exe_b, exe_rn, exe_bpc};
  assign w_accept = exe_valid & exe_ready;
  assign w_xfer   = r_main_valid & mem_ready;

`ifdef EXE_MEM_SKID_EN
  logic             r_skid_valid;
  logic [ENT_W-1:0] r_skid;
  logic             r_ready;
  logic             w_main_free;

  // exe_ready tracks "skid empty" as its own flop, so mem_ready never
  // reaches it combinationally. An accept is only possible while the skid
  // is empty, so the skid never needs to take a new entry while draining.
  assign exe_ready   = r_ready;
  assign w_main_free = ~r_main_valid | mem_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_main_valid <= 1'b0;
      r_main       <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_ready      <= 1'b1;
    end else if (flush) begin
      // Data registers keep their contents so outputs hold their last value.
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
        r_ready      <= 1'b1;
      end else if (w_accept) begin
        r_main       <= w_in_ent;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_in_ent;
      r_skid_valid <= 1'b1;
      r_ready      <= 1'b0;
    end
  end
`else
  assign exe_ready = mem_ready | ~r_main_valid;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_main_valid <= 1'b0;
      r_main       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_accept) begin
      r_main       <= w_in_ent;
      r_main_valid <= 1'b1;
    end else if (w_xfer) begin
      r_main_valid <= 1'b0;
    end
  end
`endif

  assign {w_wreg, w_m2reg, w_wmem, w_branch, mem_alu, mem_b, mem_rn, mem_bpc} = r_main;

  assign mem_valid  = r_main_valid;
  assign mem_wreg   = w_wreg   & r_main_valid;
  assign mem_m2reg  = w_m2reg  & r_main_valid;
  assign mem_wmem   = w_wmem   & r_main_valid;
  assign mem_branch = w_branch & r_main_valid;

  // A completed MEM handshake retires the entry, so it is counted even if a
  // flush arrives in the same cycle; flush itself never touches the count.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (w_xfer & w_branch) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign branch_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exe_mem_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_mem_stage_reg
// Purpose  : Self-checking bench for exe_mem_stage_reg. A FIFO-based
//            reference model predicts every output each cycle; directed
//            tables and sequences cover streaming, branch decode, stall,
//            flush, counter wrap (second instance with CNT_W=2) and
//            asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_mem_stage_reg;

  localparam int DATA_W = 32;
  localparam int RN_W   = 5;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 16;
`ifdef EXE_MEM_SKID_EN
  localparam int CAP  = 2;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = 1;
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              exe_valid = 1'b0;
  logic              exe_wreg = 1'b0, exe_m2reg = 1'b0, exe_wmem = 1'b0;
  logic [DATA_W-1:0] exe_alu = '0, exe_b = '0;
  logic [RN_W-1:0]   exe_rn = '0;
  logic              exe_z = 1'b0, exe_neg = 1'b0;
  logic [2:0]        exe_bcond = '0;
  logic [PC_W-1:0]   exe_bpc = '0;
  logic              flush = 1'b0;
  logic              mem_ready = 1'b0;

  logic              exe_ready, mem_valid;
  logic              mem_wreg, mem_m2reg, mem_wmem, mem_branch;
  logic [DATA_W-1:0] mem_alu, mem_b;
  logic [RN_W-1:0]   mem_rn;
  logic [PC_W-1:0]   mem_bpc;
  logic [CNT_W-1:0]  branch_cnt;

  logic              d2_exe_ready, d2_mem_valid;
  logic              d2_mem_wreg, d2_mem_m2reg, d2_mem_wmem, d2_mem_branch;
  logic [DATA_W-1:0] d2_mem_alu, d2_mem_b;
  logic [RN_W-1:0]   d2_mem_rn;
  logic [PC_W-1:0]   d2_mem_bpc;
  logic [1:0]        d2_branch_cnt;

  always #5 clk = ~clk;

  exe_mem_stage_reg #(.DATA_W(DATA_W), .RN_W(RN_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .exe_valid(exe_valid), .exe_ready(exe_ready),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem),
    .exe_alu(exe_alu), .exe_b(exe_b), .exe_rn(exe_rn), .exe_z(exe_z),
    .exe_neg(exe_neg), .exe_bcond(exe_bcond), .exe_bpc(exe_bpc), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wreg(mem_wreg),
    .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem), .mem_branch(mem_branch),
    .mem_alu(mem_alu), .mem_b(mem_b), .mem_rn(mem_rn), .mem_bpc(mem_bpc),
    .branch_cnt(branch_cnt)
  );

  exe_mem_stage_reg #(.DATA_W(DATA_W), .RN_W(RN_W), .PC_W(PC_W), .CNT_W(2)) dut_w2 (
    .clk(clk), .clr(clr), .exe_valid(exe_valid), .exe_ready(d2_exe_ready),
    .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg), .exe_wmem(exe_wmem),
    .exe_alu(exe_alu), .exe_b(exe_b), .exe_rn(exe_rn), .exe_z(exe_z),
    .exe_neg(exe_neg), .exe_bcond(exe_bcond), .exe_bpc(exe_bpc), .flush(flush),
    .mem_valid(d2_mem_valid), .mem_ready(mem_ready), .mem_wreg(d2_mem_wreg),
    .mem_m2reg(d2_mem_m2reg), .mem_wmem(d2_mem_wmem), .mem_branch(d2_mem_branch),
    .mem_alu(d2_mem_alu), .mem_b(d2_mem_b), .mem_rn(d2_mem_rn), .mem_bpc(d2_mem_bpc),
    .branch_cnt(d2_branch_cnt)
  );

  // ---------------- reference model: a bounded FIFO of entries ----------------
  typedef struct {
    logic              wreg, m2reg, wmem, br;
    logic [DATA_W-1:0] alu, b;
    logic [RN_W-1:0]   rn;
    logic [PC_W-1:0]   bpc;
  } ent_t;

  typedef struct {
    logic [2:0] bcond;
    logic       z, neg, exp;
  } vec_t;

  ent_t        q[$];
  ent_t        last;
  int unsigned cnt;
  bit          last_acc;
  logic [DATA_W-1:0] seen[$];
  int checks = 0;
  int errors = 0;

  function automatic logic taken(input logic [2:0] c, input logic z, input logic n);
    case (c)
      3'd0: return 1'b0;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return z || n;
      3'd4: return !z && !n;
      3'd5: return n;
      3'd6: return !n;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit model_ready();
    if (SKID) return q.size() < CAP;
    return (q.size() == 0) || mem_ready;
  endfunction

  function automatic ent_t cur_entry();
    ent_t e;
    e.wreg = exe_wreg; e.m2reg = exe_m2reg; e.wmem = exe_wmem;
    e.br = taken(exe_bcond, exe_z, exe_neg);
    e.alu = exe_alu; e.b = exe_b; e.rn = exe_rn; e.bpc = exe_bpc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last = '{default: '0};
    cnt = 0;
  endtask

  task automatic check_outputs();
    ent_t f;
    bit   v;
    v = q.size() > 0;
    f = v ? q[0] : last;
    chk("mem_valid",  mem_valid,  v);
    chk("mem_wreg",   mem_wreg,   v & f.wreg);
    chk("mem_m2reg",  mem_m2reg,  v & f.m2reg);
    chk("mem_wmem",   mem_wmem,   v & f.wmem);
    chk("mem_branch", mem_branch, v & f.br);
    chk("mem_alu",    mem_alu,    f.alu);
    chk("mem_b",      mem_b,      f.b);
    chk("mem_rn",     mem_rn,     f.rn);
    chk("mem_bpc",    mem_bpc,    f.bpc);
    chk("exe_ready",  exe_ready,  model_ready());
    chk("branch_cnt", branch_cnt, cnt[CNT_W-1:0]);
    chk("branch_cnt_w2", d2_branch_cnt, cnt[1:0]);
  endtask

  // Called 1 time unit after a rising edge with inputs already driven;
  // checks at the falling edge, advances the model at the next rising edge.
  task automatic step();
    bit acc, xfer;
    @(negedge clk);
    check_outputs();
    acc  = exe_valid && model_ready();
    xfer = (q.size() > 0) && mem_ready;
    if (mem_valid && mem_ready) seen.push_back(mem_alu);
    @(posedge clk);
    if (xfer) begin
      if (q[0].br) cnt++;
      last = q[0];
      void'(q.pop_front());
    end
    if (flush) q.delete();
    else if (acc) q.push_back(cur_entry());
    if (q.size() > 0) last = q[0];
    last_acc = acc;
    #1;
  endtask

  // Asserts clr between edges and checks the immediate effect.
  task automatic async_reset();
    #1 clr = 1'b1;
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_controls", {mem_wreg, mem_m2reg, mem_wmem, mem_branch}, 0);
    chk("rst_mem_alu", mem_alu, 0);
    chk("rst_mem_b", mem_b, 0);
    chk("rst_mem_rn", mem_rn, 0);
    chk("rst_mem_bpc", mem_bpc, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_exe_ready", exe_ready, 1);
    model_reset();
    clr = 1'b0;
  endtask

  task automatic set_entry(input logic [DATA_W-1:0] alu, input logic [2:0] bc,
                           input logic z, input logic n, input logic wm);
    exe_wreg = 1'b1; exe_m2reg = alu[0]; exe_wmem = wm;
    exe_alu = alu; exe_b = ~alu; exe_rn = alu[RN_W-1:0];
    exe_z = z; exe_neg = n; exe_bcond = bc; exe_bpc = alu << 2;
  endtask

  task automatic set_random();
    exe_valid = $urandom_range(0, 3) != 0;
    mem_ready = $urandom_range(0, 2) != 0;
    flush     = $urandom_range(0, 19) == 0;
    exe_wreg  = 1'($urandom); exe_m2reg = 1'($urandom); exe_wmem = 1'($urandom);
    exe_alu   = $urandom; exe_b = $urandom; exe_rn = RN_W'($urandom);
    exe_z     = 1'($urandom); exe_neg = 1'($urandom);
    exe_bcond = 3'($urandom); exe_bpc = $urandom;
  endtask

  initial begin
    vec_t        tbl[16];
    logic [7:0]  exp_a = 8'b1100_1010;   // z=1,neg=0, bcond 0..7 (LSB first)
    logic [7:0]  exp_b = 8'b1010_1100;   // z=0,neg=1, bcond 0..7 (LSB first)
    int          k;
    int unsigned saved;

    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{bcond: 3'(i), z: 1'b1, neg: 1'b0, exp: exp_a[i]};
      tbl[i + 8] = '{bcond: 3'(i), z: 1'b0, neg: 1'b1, exp: exp_b[i]};
    end

    // Reset at start, aligned to 1 unit after a rising edge afterwards.
    #1;
    async_reset();
    @(posedge clk);
    #1;

    // Streaming at full throughput.
    mem_ready = 1'b1;
    exe_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_entry(DATA_W'(i), 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk("stream_alu", mem_alu, i);
      chk("stream_valid", mem_valid, 1);
      chk("stream_ready", exe_ready, 1);
    end
    exe_valid = 1'b0;
    step();

    // Branch decode table.
    exe_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_entry(DATA_W'(32'h100 + i), tbl[i].bcond, tbl[i].z, tbl[i].neg, 1'b0);
      step();
      chk("bcond_table", mem_branch, tbl[i].exp);
    end
    exe_valid = 1'b0;
    step();

    // Five taken transfers from reset; narrow counter wraps 1,2,3,0,1.
    async_reset();
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      exe_valid = (i < 5);
      set_entry(DATA_W'(32'h20 + i), 3'd7, 1'b0, 1'b0, 1'b0);
      step();
      if (i >= 1) chk("wrap_seq", d2_branch_cnt, i % 4);
    end
    chk("five_taken", branch_cnt, 5);
    exe_valid = 1'b0;

    // Back-pressure: three entries offered while MEM stalls.
    async_reset();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      exe_valid = (k < 3);
      set_entry(DATA_W'(32'h10 + k), 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      if (last_acc) k++;
      chk("bp_ready", exe_ready, SKID ? (k < 2) : (k == 0));
      chk("bp_alu_stable", mem_alu, 32'h10);
    end
    chk("bp_accepted", k, CAP);
    seen.delete();
    mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exe_valid = (k < 3);
      set_entry(DATA_W'(32'h10 + k), 3'd0, 1'b0, 1'b0, 1'b0);
      step();
      if (last_acc) k++;
    end
    exe_valid = 1'b0;
    chk("bp_count", seen.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", (i < seen.size()) ? seen[i] : 32'hDEAD, 32'h10 + i);

    // Flush with pipe full and a simultaneous accept.
    mem_ready = 1'b0;
    exe_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_entry(DATA_W'(32'h40 + c), 3'd7, 1'b0, 1'b0, 1'b1);
      step();
    end
    saved = cnt;
    set_entry(32'h77, 3'd7, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exe_valid = 1'b0;
    chk("flush_valid", mem_valid, 0);
    chk("flush_wmem", mem_wmem, 0);
    chk("flush_branch", mem_branch, 0);
    chk("flush_cnt", branch_cnt, saved);
    mem_ready = 1'b1;
    step();
    chk("flush_cnt_after", branch_cnt, saved);

    // Asynchronous clr mid-stream, then first accept after release.
    exe_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      set_entry(DATA_W'(32'h60 + c), 3'd7, 1'b0, 1'b0, 1'b0);
      step();
    end
    exe_valid = 1'b0;
    async_reset();
    exe_valid = 1'b1;
    set_entry(32'h55, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    exe_valid = 1'b0;
    chk("post_rst_valid", mem_valid, 1);
    chk("post_rst_alu", mem_alu, 32'h55);

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      set_random();
      step();
    end
    flush = 1'b0;
    exe_valid = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_mem_stage_reg.md
# exe_mem_stage_reg

Parametrised elastic EXE/MEM pipeline register with integrated branch resolution, stall back-pressure and flush. It sits between the execute stage and the memory stage and captures ALU result, store data, destination register, write-control bits and branch target. It resolves an 8-way branch condition from the ALU zero and negative flags, and counts taken branches retired into MEM. It supersedes the fixed 32-bit, beq/bne-only EXE/MEM register.

## Interface
- DATA_W, 32, width of ALU result and store data
- RN_W, 5, destination register index width
- PC_W, 32, branch target width
- CNT_W, 16, taken-branch counter width
- clk  in  1  one clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- exe_valid  in  1  EXE offers an entry
- exe_ready  out  1  block can accept an entry
- exe_wreg, exe_m2reg, exe_wmem  in  1 each  write controls
- exe_alu, exe_b  in  DATA_W  ALU result, store data
- exe_rn  in  RN_W  destination register
- exe_z, exe_neg  in  1  ALU zero and sign flags
- exe_bcond  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 always
- exe_bpc  in  PC_W  branch target
- flush  in  1  synchronous kill of all held entries
- mem_valid  out  1  output entry valid
- mem_ready  in  1  MEM consumes entry
- mem_wreg, mem_m2reg, mem_wmem, mem_branch  out  1  controls, 0 whenever mem_valid=0
- mem_alu, mem_b  out  DATA_W; mem_rn  out  RN_W; mem_bpc  out  PC_W
- branch_cnt  out  CNT_W  taken branches retired

## Operation
- Accept when exe_valid & exe_ready. Transfer out when mem_valid & mem_ready.
- Taken = beq:z; bne:~z; blez:z|neg; bgtz:~z&~neg; bltz:neg; bgez:~neg; always:1; none:0. It is evaluated at accept and stored as the entry's branch bit.
- mem_wreg/m2reg/wmem/branch are the stored bits ANDed with mem_valid. Data outputs hold their last value when the entry is invalid.
- flush=1 clears all valid bits on the next edge. An entry accepted in the same cycle is dropped, so flush wins. branch_cnt does not count an entry flushed before it transfers.
- branch_cnt increments by 1 on each transfer with mem_branch=1 and wraps from 2^CNT_W-1 to 0. flush does not clear it.
- Entries leave in acceptance order. No entry is duplicated or lost except by flush.

## Timing
- Reset (clr=1, asynchronous): mem_valid=0, all mem_* controls 0, mem_alu/mem_b/mem_rn/mem_bpc=0, branch_cnt=0, skid empty, exe_ready=1.
- Latency: an entry accepted at edge N is visible on mem_* after edge N, with mem_valid=1 in cycle N+1.
- Full throughput (1 entry/cycle) when mem_ready is held at 1.
- mem_valid=1 with mem_ready=0: all mem_* outputs stay stable until transfer.
- If clr asserts mid-transfer, the entry is discarded and outputs go to reset values immediately.

## Configuration
- EXE_MEM_SKID_EN defined:
  - Adds a one-entry skid register, so exe_ready is a flop with no combinational path from mem_ready.
  - exe_ready falls in the cycle after an accept that lands in the skid (main full, mem_ready=0).
  - It rises in the cycle after the skid drains into main.
  - Capacity is 2 entries.
- Undefined:
  - Single register only; capacity is 1 entry.
  - exe_ready = mem_ready | ~mem_valid, combinational.
  - flush behaviour and branch logic are identical in both builds.

## Test plan
- Reset, then stream 4 entries with alu=1..4 and mem_ready=1: mem_alu=1,2,3,4 on consecutive cycles starting 1 cycle after the first accept; exe_ready stays 1.
- Branch table: z=1,neg=0 with each bcond 000..111 gives mem_branch 0,1,0,1,0,0,1,1. z=0,neg=1 gives 0,0,1,1,0,1,0,1. After 5 taken transfers from reset, branch_cnt=5.
- Back-pressure: mem_ready=0 while 3 entries are offered.
  - With EXE_MEM_SKID_EN: 2 accepted, exe_ready=0 from the cycle after the second accept, outputs stable.
  - Without it: 1 accepted.
  - After releasing mem_ready, entries emerge in order with none lost.
- Flush with the pipe full and a simultaneous accept (wmem=1, bcond=111): next cycle mem_valid=0, mem_wmem=0, mem_branch=0, and branch_cnt is unchanged.
- Counter wrap with CNT_W=2: 5 taken transfers give branch_cnt sequence 1,2,3,0,1.
- Asynchronous clr mid-stream between edges: outputs drop to 0 immediately and exe_ready=1. The first accept after release reappears 1 cycle later.
